// File: rtl/sprite_physics_engine.sv
// ---------------------------------------------------------------------------
// sprite_physics_engine
//
// Per-frame kinematics engine for up to NUM_OBJ sprites. Each frame_tick
// starts one pass that walks the objects in index order through three states:
//   VEL : velocity update (gravity, jump, x command)
//   POS : position integration into a wide signed scratch sum
//   FIX : clamp to inclusive bounds; balls reflect velocity and pulse bounce
// One shared arithmetic path serves all objects.
//
// Optional feature (macro PHYS_COLLIDE_EN): balls get an extra COLL state
// after FIX in which the ball is tested against every player object. The
// lowest-index overlapping player launches the ball upward and away from it.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   frame_tick            single-cycle pulse starting one update pass
//   obj_mode              2 bits/object: 00 static, 01 player, 10 ball, 11 static
//   obj_vx_cmd, obj_jump  player x velocity command and jump request
//   obj_xmin..obj_ymax    inclusive per-object bounds
//   load_en, load_idx,
//   load_x/y, load_vx/vy  object state write (accepted only while not busy)
//   pos_x/pos_y, vel_x/vel_y  registered object state
//   bounce                one-cycle pulse per ball clamped (or hit) this pass
//   busy, done, overrun   pass in progress, end-of-pass pulse, sticky overrun
// ---------------------------------------------------------------------------
module sprite_physics_engine #(
  parameter int NUM_OBJ  = 3,
  parameter int COORD_W  = 10,
  parameter int VEL_W    = 8,
  parameter int GRAVITY  = 1,
  parameter int GRAV_DIV = 6,
  parameter int JUMP_V   = 21,
  parameter int VMAX     = 21,
  parameter int HALF     = 27
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       frame_tick,
  input  logic [2*NUM_OBJ-1:0]       obj_mode,
  input  logic [VEL_W*NUM_OBJ-1:0]   obj_vx_cmd,
  input  logic [NUM_OBJ-1:0]         obj_jump,
  input  logic [COORD_W*NUM_OBJ-1:0] obj_xmin,
  input  logic [COORD_W*NUM_OBJ-1:0] obj_xmax,
  input  logic [COORD_W*NUM_OBJ-1:0] obj_ymin,
  input  logic [COORD_W*NUM_OBJ-1:0] obj_ymax,
  input  logic                       load_en,
  input  logic [2:0]                 load_idx,
  input  logic [COORD_W-1:0]         load_x,
  input  logic [COORD_W-1:0]         load_y,
  input  logic [VEL_W-1:0]           load_vx,
  input  logic [VEL_W-1:0]           load_vy,
  output logic [COORD_W*NUM_OBJ-1:0] pos_x,
  output logic [COORD_W*NUM_OBJ-1:0] pos_y,
  output logic [VEL_W*NUM_OBJ-1:0]   vel_x,
  output logic [VEL_W*NUM_OBJ-1:0]   vel_y,
  output logic [NUM_OBJ-1:0]         bounce,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  localparam int SW    = COORD_W + 2;
  localparam int CNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  // Elaboration-time configuration guard.
  if (NUM_OBJ < 1 || NUM_OBJ > 8 || GRAV_DIV < 1 || HALF < 1) begin : g_bad_cfg
    $error("sprite_physics_engine: unsupported parameter set");
  end

  typedef logic signed [SW-1:0]    sum_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [2:0] {S_IDLE, S_VEL, S_POS, S_FIX, S_COLL, S_DONE} state_e;

  localparam vel_t VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
  localparam vel_t VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};

  state_e             state;
  logic [2:0]         idx;
  logic [CNT_W-1:0]   frame_cnt;
  logic               grav_frame;
  sum_t               sx, sy;

  // Current-object view of the packed buses.
  logic [1:0]         cur_mode;
  logic [COORD_W-1:0] cur_x, cur_y, cur_xmin, cur_xmax, cur_ymin, cur_ymax;
  vel_t               cur_vx, cur_vy, cur_vx_cmd, vy_grav;
  logic               is_player, is_ball, last_obj, load_ok, accept;
  logic [CNT_W-1:0]   cnt_next, start_cnt;
  sum_t               sum_x, sum_y;
  logic               x_lo, x_hi, y_lo, y_hi;
  logic [COORD_W-1:0] fix_x, fix_y;
  int                 vy_dec;

  // Negation that maps the most negative code onto the most positive one.
  function automatic vel_t neg_sat(input vel_t v);
    return (v == VEL_MIN) ? VEL_MAX : -v;
  endfunction

  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cur_mode   = obj_mode[2*idx +: 2];
    cur_x      = pos_x[COORD_W*idx +: COORD_W];
    cur_y      = pos_y[COORD_W*idx +: COORD_W];
    cur_vx     = vel_x[VEL_W*idx +: VEL_W];
    cur_vy     = vel_y[VEL_W*idx +: VEL_W];
    cur_vx_cmd = obj_vx_cmd[VEL_W*idx +: VEL_W];
    cur_xmin   = obj_xmin[COORD_W*idx +: COORD_W];
    cur_xmax   = obj_xmax[COORD_W*idx +: COORD_W];
    cur_ymin   = obj_ymin[COORD_W*idx +: COORD_W];
    cur_ymax   = obj_ymax[COORD_W*idx +: COORD_W];
    is_player  = (cur_mode == 2'b01);
    is_ball    = (cur_mode == 2'b10);
    last_obj   = (int'(idx) == NUM_OBJ - 1);
    load_ok    = load_en && (int'(load_idx) < NUM_OBJ);
    accept     = (state == S_IDLE) || (state == S_DONE);

    cnt_next   = (frame_cnt == CNT_W'(GRAV_DIV - 1)) ? '0 : frame_cnt + 1'b1;
    // A tick taken in the DONE cycle starts against the advanced counter.
    start_cnt  = (state == S_DONE) ? cnt_next : frame_cnt;

    vy_dec     = int'(cur_vy) - GRAVITY;
    if (vy_dec < -VMAX) vy_dec = -VMAX;
    vy_grav    = VEL_W'(vy_dec);

    // Screen y grows downward while vy is up-positive, hence the subtraction.
    sum_x      = $signed({2'b00, cur_x}) + SW'(cur_vx);
    sum_y      = $signed({2'b00, cur_y}) - SW'(cur_vy);

    x_lo       = sx < $signed({2'b00, cur_xmin});
    x_hi       = sx > $signed({2'b00, cur_xmax});
    y_lo       = sy < $signed({2'b00, cur_ymin});
    y_hi       = sy > $signed({2'b00, cur_ymax});
    fix_x      = x_lo ? cur_xmin : (x_hi ? cur_xmax : sx[COORD_W-1:0]);
    fix_y      = y_lo ? cur_ymin : (y_hi ? cur_ymax : sy[COORD_W-1:0]);
  end

`ifdef PHYS_COLLIDE_EN
  logic               hit;
  logic [COORD_W-1:0] hit_px;
  int                 dx, dy;
  vel_t               abs_vx;

  // Descending scan so the lowest-index overlapping player is the one kept.
  always_comb begin
    hit    = 1'b0;
    hit_px = '0;
    dx     = 0;
    dy     = 0;
    for (int j = NUM_OBJ - 1; j >= 0; j--) begin
      dx = int'(pos_x[COORD_W*j +: COORD_W]) - int'(cur_x);
      dy = int'(pos_y[COORD_W*j +: COORD_W]) - int'(cur_y);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (obj_mode[2*j +: 2] == 2'b01 && j != int'(idx) &&
          dx < 2*HALF && dy < 2*HALF) begin
        hit    = 1'b1;
        hit_px = pos_x[COORD_W*j +: COORD_W];
      end
    end
    abs_vx = cur_vx[VEL_W-1] ? neg_sat(cur_vx) : cur_vx;
  end
`endif

  // NOTE: sequential state is written only with non-blocking assignments so
  // every read in this block sees the value from before the clock edge.
  // NOTE: the object state registers are reset because the sprite address
  // logic consumes them directly and must see a defined origin after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      frame_cnt  <= '0;
      grav_frame <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      vel_x      <= '0;
      vel_y      <= '0;
      bounce     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      bounce <= '0;
      done   <= 1'b0;
      if (frame_tick && !accept) overrun <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) frame_cnt <= cnt_next;
          if (load_ok) begin
            pos_x[COORD_W*load_idx +: COORD_W] <= load_x;
            pos_y[COORD_W*load_idx +: COORD_W] <= load_y;
            vel_x[VEL_W*load_idx +: VEL_W]     <= load_vx;
            vel_y[VEL_W*load_idx +: VEL_W]     <= load_vy;
          end
          if (frame_tick) begin
            state      <= S_VEL;
            idx        <= '0;
            busy       <= 1'b1;
            grav_frame <= (start_cnt == '0);
          end else begin
            state <= S_IDLE;
          end
        end

        S_VEL: begin
          if (is_player) begin
            vel_x[VEL_W*idx +: VEL_W] <= cur_vx_cmd;
            if (cur_y == cur_ymax)
              vel_y[VEL_W*idx +: VEL_W] <= obj_jump[idx] ? VEL_W'(JUMP_V) : '0;
            else if (grav_frame)
              vel_y[VEL_W*idx +: VEL_W] <= vy_grav;
          end else if (is_ball && grav_frame) begin
            vel_y[VEL_W*idx +: VEL_W] <= vy_grav;
          end
          state <= S_POS;
        end

        S_POS: begin
          sx    <= sum_x;
          sy    <= sum_y;
          state <= S_FIX;
        end

        S_FIX: begin
          if (is_player || is_ball) begin
            pos_x[COORD_W*idx +: COORD_W] <= fix_x;
            pos_y[COORD_W*idx +: COORD_W] <= fix_y;
          end
          if (is_ball) begin
            if (x_lo || x_hi) vel_x[VEL_W*idx +: VEL_W] <= neg_sat(cur_vx);
            if (y_lo || y_hi) vel_y[VEL_W*idx +: VEL_W] <= neg_sat(cur_vy);
            if (x_lo || x_hi || y_lo || y_hi) bounce[idx] <= 1'b1;
          end
`ifdef PHYS_COLLIDE_EN
          if (is_ball) begin
            state <= S_COLL;
          end else
`endif
          if (last_obj) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + 3'd1;
            state <= S_VEL;
          end
        end

`ifdef PHYS_COLLIDE_EN
        S_COLL: begin
          if (hit) begin
            vel_y[VEL_W*idx +: VEL_W] <= VEL_W'(JUMP_V);
            vel_x[VEL_W*idx +: VEL_W] <= (cur_x < hit_px) ? -abs_vx : abs_vx;
            bounce[idx]               <= 1'b1;
          end
          if (last_obj) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + 3'd1;
            state <= S_VEL;
          end
        end
`endif

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_physics_engine.sv
// ---------------------------------------------------------------------------
// tb_sprite_physics_engine
//
// Self-checking bench for sprite_physics_engine (default build, NUM_OBJ=3).
// A behavioural reference model of one pass runs when each frame_tick is
// driven; its expected object state is queued and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_sprite_physics_engine;

  localparam int N  = 3;
  localparam int CW = 10;
  localparam int VW = 8;

  typedef struct packed {
    logic [N-1:0][CW-1:0] x;
    logic [N-1:0][CW-1:0] y;
    logic [N-1:0][VW-1:0] vx;
    logic [N-1:0][VW-1:0] vy;
    logic [N-1:0]         bnc;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                frame_tick = 1'b0;
  logic [2*N-1:0]      obj_mode = '0;
  logic [VW*N-1:0]     obj_vx_cmd = '0;
  logic [N-1:0]        obj_jump = '0;
  logic [CW*N-1:0]     obj_xmin = '0, obj_xmax = '0, obj_ymin = '0, obj_ymax = '0;
  logic                load_en = 1'b0;
  logic [2:0]          load_idx = '0;
  logic [CW-1:0]       load_x = '0, load_y = '0;
  logic [VW-1:0]       load_vx = '0, load_vy = '0;
  logic [CW*N-1:0]     pos_x, pos_y;
  logic [VW*N-1:0]     vel_x, vel_y;
  logic [N-1:0]        bounce;
  logic                busy, done, overrun;

  sprite_physics_engine dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .obj_mode(obj_mode), .obj_vx_cmd(obj_vx_cmd), .obj_jump(obj_jump),
    .obj_xmin(obj_xmin), .obj_xmax(obj_xmax), .obj_ymin(obj_ymin), .obj_ymax(obj_ymax),
    .load_en(load_en), .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
    .load_vx(load_vx), .load_vy(load_vy),
    .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
    .bounce(bounce), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Stimulus configuration and reference model state.
  int t_mode[N], t_vxc[N], t_jump[N], t_xmin[N], t_xmax[N], t_ymin[N], t_ymax[N];
  int m_x[N], m_y[N], m_vx[N], m_vy[N];
  int m_cnt;
  int bcnt[N];
  exp_t sb_q[$];

  function automatic int dut_x(int i);  return int'(pos_x[CW*i +: CW]); endfunction
  function automatic int dut_y(int i);  return int'(pos_y[CW*i +: CW]); endfunction
  function automatic int dut_vx(int i); return int'($signed(vel_x[VW*i +: VW])); endfunction
  function automatic int dut_vy(int i); return int'($signed(vel_y[VW*i +: VW])); endfunction

  function automatic int sat_neg(int v); return (v == -128) ? 127 : -v; endfunction

  task automatic set_obj(int i, int mode, int xmin, int xmax, int ymin, int ymax);
    t_mode[i] = mode; t_xmin[i] = xmin; t_xmax[i] = xmax;
    t_ymin[i] = ymin; t_ymax[i] = ymax; t_vxc[i] = 0; t_jump[i] = 0;
  endtask

  task automatic drive_cfg();
    for (int i = 0; i < N; i++) begin
      obj_mode[2*i +: 2]     = 2'(t_mode[i]);
      obj_vx_cmd[VW*i +: VW] = VW'(t_vxc[i]);
      obj_jump[i]            = (t_jump[i] != 0);
      obj_xmin[CW*i +: CW]   = CW'(t_xmin[i]);
      obj_xmax[CW*i +: CW]   = CW'(t_xmax[i]);
      obj_ymin[CW*i +: CW]   = CW'(t_ymin[i]);
      obj_ymax[CW*i +: CW]   = CW'(t_ymax[i]);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; frame_tick = 1'b0; load_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_obj(i, 0, 0, 1023, 0, 1023);
      m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
    end
    m_cnt = 0;
    sb_q.delete();
    drive_cfg();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Drives the load bus; the caller decides which edge samples it.
  task automatic put_load(int i, int x, int y, int vx, int vy);
    load_en = 1'b1; load_idx = 3'(i);
    load_x = CW'(x); load_y = CW'(y); load_vx = VW'(vx); load_vy = VW'(vy);
    if (i < N) begin
      m_x[i] = x; m_y[i] = y; m_vx[i] = vx; m_vy[i] = vy;
    end
  endtask

  task automatic load_obj(int i, int x, int y, int vx, int vy);
    put_load(i, x, y, vx, vy);
    @(posedge clk); #1 load_en = 1'b0;
  endtask

  // Reference model: one full pass over all objects, pushed to the scoreboard.
  task automatic model_pass();
    exp_t e;
    bit   grav;
    grav = (m_cnt == 0);
    e = '0;
    for (int i = 0; i < N; i++) begin
      int nx, ny;
      if (t_mode[i] == 1) begin
        m_vx[i] = t_vxc[i];
        if (m_y[i] == t_ymax[i]) m_vy[i] = (t_jump[i] != 0) ? 21 : 0;
        else if (grav) m_vy[i] = (m_vy[i] - 1 < -21) ? -21 : m_vy[i] - 1;
      end else if (t_mode[i] == 2 && grav) begin
        m_vy[i] = (m_vy[i] - 1 < -21) ? -21 : m_vy[i] - 1;
      end
      if (t_mode[i] == 1 || t_mode[i] == 2) begin
        bit cx, cy;
        nx = m_x[i] + m_vx[i];
        ny = m_y[i] - m_vy[i];
        cx = (nx < t_xmin[i]) || (nx > t_xmax[i]);
        cy = (ny < t_ymin[i]) || (ny > t_ymax[i]);
        if (nx < t_xmin[i]) nx = t_xmin[i]; else if (nx > t_xmax[i]) nx = t_xmax[i];
        if (ny < t_ymin[i]) ny = t_ymin[i]; else if (ny > t_ymax[i]) ny = t_ymax[i];
        m_x[i] = nx; m_y[i] = ny;
        if (t_mode[i] == 2) begin
          if (cx) m_vx[i] = sat_neg(m_vx[i]);
          if (cy) m_vy[i] = sat_neg(m_vy[i]);
          e.bnc[i] = cx || cy;
        end
      end
      e.x[i] = CW'(m_x[i]); e.y[i] = CW'(m_y[i]);
      e.vx[i] = VW'(m_vx[i]); e.vy[i] = VW'(m_vy[i]);
    end
    m_cnt = (m_cnt + 1) % 6;
    sb_q.push_back(e);
  endtask

  // Clocks the DUT, collecting bounce pulses and done pulses. frame_tick and
  // load_en are dropped after the first edge.
  task automatic observe(input int max_cyc, input bit stop_on_done,
                         output int lat, output int ndone);
    lat = 0; ndone = 0;
    for (int i = 0; i < N; i++) bcnt[i] = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0; load_en = 1'b0;
      lat++;
      for (int i = 0; i < N; i++) if (bounce[i]) bcnt[i]++;
      if (done) begin
        ndone++;
        if (stop_on_done) break;
      end
    end
  endtask

  task automatic score(string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      failures++; checks++;
      $display("FAIL %s scoreboard empty at compare", tag);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (pos_x[CW*i +: CW] !== e.x[i] || pos_y[CW*i +: CW] !== e.y[i] ||
          vel_x[VW*i +: VW] !== e.vx[i] || vel_y[VW*i +: VW] !== e.vy[i]) begin
        failures++;
        $display("FAIL %s obj%0d state got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)",
                 tag, i, dut_x(i), dut_y(i), dut_vx(i), dut_vy(i),
                 e.x[i], e.y[i], $signed(e.vx[i]), $signed(e.vy[i]));
      end
      checks++;
      if (bcnt[i] !== int'(e.bnc[i])) begin
        failures++;
        $display("FAIL %s obj%0d bounce pulses got %0d want %0d", tag, i, bcnt[i], e.bnc[i]);
      end
    end
  endtask

  // One pass: model, tick, wait for done (bounded), latency check, compare.
  task automatic run_pass(string tag);
    int lat, nd;
    model_pass();
    frame_tick = 1'b1;
    observe(40, 1'b1, lat, nd);
    checks++;
    if (nd != 1) begin
      failures++;
      $display("FAIL %s done timeout got %0d pulses want 1", tag, nd);
    end else if (lat != 3*N + 1) begin
      failures++;
      $display("FAIL %s done latency got %0d want %0d", tag, lat, 3*N + 1);
    end
    score(tag);
  endtask

  task automatic expect_int(string tag, int got, int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (pos_x !== '0 || pos_y !== '0 || vel_x !== '0 || vel_y !== '0 ||
        bounce !== '0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got px=%h py=%h vx=%h vy=%h b=%b busy=%b done=%b ovr=%b want all 0",
               pos_x, pos_y, vel_x, vel_y, bounce, busy, done, overrun);
    end
  endtask

  task automatic test_reset_mid_pass();
    int lat, nd;
    do_reset();
    set_obj(0, 2, 27, 613, 0, 479); drive_cfg();
    load_obj(0, 300, 200, 4, 3);
    frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_int("mid_pass_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    checks++;
    if (pos_x !== '0 || pos_y !== '0 || vel_x !== '0 || vel_y !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_pass_reset got px=%h py=%h vx=%h vy=%h busy=%b want all 0",
               pos_x, pos_y, vel_x, vel_y, busy);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    observe(20, 1'b0, lat, nd);
    expect_int("mid_pass_no_done", nd, 0);
  endtask

  task automatic test_ball_bounce();
    do_reset();
    set_obj(0, 2, 27, 613, 0, 479);
    set_obj(1, 0, 0, 1023, 0, 1023);
    set_obj(2, 3, 0, 1023, 0, 1023);
    drive_cfg();
    load_obj(0, 610, 200, 5, 0);
    run_pass("ball_bounce");
    expect_int("ball_x_clamped", dut_x(0), 613);
    expect_int("ball_vx_reflected", dut_vx(0), -5);
    expect_int("ball_bounce_pulses", bcnt[0], 1);
  endtask

  task automatic test_player_jump();
    do_reset();
    set_obj(1, 1, 0, 1023, 0, 401);
    t_jump[1] = 1;
    drive_cfg();
    load_obj(1, 300, 401, 0, 0);
    run_pass("jump_pass1");
    expect_int("jump_vy", dut_vy(1), 21);
    expect_int("jump_y", dut_y(1), 380);
    t_jump[1] = 0; drive_cfg();
    run_pass("jump_pass2");
    expect_int("rise_y", dut_y(1), 359);
    expect_int("rise_vy", dut_vy(1), 21);
  endtask

  task automatic test_gravity();
    do_reset();
    set_obj(0, 2, 0, 1023, 0, 1023); drive_cfg();
    load_obj(0, 300, 100, 0, 0);
    for (int p = 1; p <= 12; p++) begin
      run_pass("gravity");
      if (p == 1) expect_int("grav_vy_pass1", dut_vy(0), -1);
      if (p == 6) expect_int("grav_vy_pass6", dut_vy(0), -1);
      if (p == 7) expect_int("grav_vy_pass7", dut_vy(0), -2);
    end
    do_reset();
    set_obj(0, 2, 0, 1023, 0, 1023); drive_cfg();
    load_obj(0, 300, 0, 0, -20);
    for (int p = 1; p <= 7; p++) run_pass("grav_sat");
    expect_int("grav_vy_saturated", dut_vy(0), -21);
  endtask

  task automatic test_overrun();
    int lat, nd;
    do_reset();
    set_obj(0, 2, 0, 1023, 0, 1023); drive_cfg();
    load_obj(0, 300, 200, 2, 0);
    model_pass();
    frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 frame_tick = 1'b1;
    observe(40, 1'b0, lat, nd);
    expect_int("overrun_done_count", nd, 1);
    expect_int("overrun_flag", int'(overrun), 1);
    score("overrun_single_update");
  endtask

  task automatic test_player_clamp();
    do_reset();
    set_obj(0, 1, 361, 700, 0, 401);
    t_vxc[0] = -5;
    set_obj(1, 0, 0, 1023, 0, 1023);
    drive_cfg();
    load_obj(0, 362, 200, 0, 0);
    load_obj(1, 100, 100, 3, 0);
    run_pass("player_clamp");
    expect_int("player_x_clamped", dut_x(0), 361);
    expect_int("player_no_bounce", bcnt[0], 0);
    expect_int("static_x", dut_x(1), 100);
    expect_int("static_vx", dut_vx(1), 3);
  endtask

  task automatic test_load_rules();
    int lat, nd;
    do_reset();
    set_obj(0, 2, 0, 1023, 0, 1023);
    set_obj(2, 2, 0, 1023, 0, 1023);
    drive_cfg();
    load_obj(0, 50, 60, 1, 2);
    load_obj(3, 999, 999, 9, 9);
    expect_int("load_idx_out_of_range", dut_x(0) + dut_x(1) + dut_x(2), 50);
    // Load coincident with frame_tick: the pass must use the loaded values.
    put_load(2, 500, 300, -7, 4);
    run_pass("load_with_tick");
    expect_int("load_with_tick_x", dut_x(2), 493);
    // Load while busy: must be dropped.
    model_pass();
    frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    load_en = 1'b1; load_idx = 3'd2; load_x = 10'd7; load_y = 10'd7;
    load_vx = '0; load_vy = '0;
    observe(40, 1'b1, lat, nd);
    expect_int("load_busy_done", nd, 1);
    score("load_while_busy");
  endtask

  // Consecutive passes with each tick coincident with the previous done,
  // covering y reflection, underflow below 0 and overflow past 1023.
  task automatic test_back_to_back();
    do_reset();
    set_obj(0, 2, 0, 1023, 0, 479);
    set_obj(1, 2, 27, 1023, 0, 1023);
    set_obj(2, 2, 0, 1023, 0, 1023);
    drive_cfg();
    load_obj(0, 300, 470, 0, -10);
    load_obj(1, 100, 500, -128, 0);
    load_obj(2, 1020, 500, 127, 0);
    for (int p = 0; p < 3; p++) run_pass("back_to_back");
    expect_int("b2b_busy_idle", int'(busy), 0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_pass();
    test_ball_bounce();
    test_player_jump();
    test_gravity();
    test_overrun();
    test_player_clamp();
    test_load_rules();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
